// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the multicycle RV32I control path.
package riscv_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   function automatic state_t decode_next(input logic [6:0] op);
      return (op == OP_LOAD || op == OP_STORE) ? S_MEMADR :
             (op == OP_R)      ? S_EXECR :
             (op == OP_IMM)    ? S_EXECI :
             (op == OP_JAL)    ? S_JAL   :
             (op == OP_BRANCH) ? S_BEQ   : S_TRAP;
   endfunction

endpackage

// File: rtl/aluDecoder.sv
// aluDecoder: maps ALUOp and instruction fields to the ALU operation code.
module aluDecoder
   import riscv_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       op5,
   output logic [3:0] ALUControl
);

   always_comb begin
      ALUControl = ALU_ADD;
      if (ALUOp == ALUOP_SUB)
         ALUControl = ALU_SUB;
      else if (ALUOp == ALUOP_FUNCT)
         case (funct3)
            // only R-type uses bit 30 to select sub; addi ignores it
            3'b000: ALUControl = (funct7_5 & op5) ? ALU_SUB : ALU_ADD;
            3'b001: ALUControl = ALU_SLL;
            3'b010: ALUControl = ALU_SLT;
            3'b011: ALUControl = ALU_SLTU;
            3'b100: ALUControl = ALU_XOR;
            3'b101: ALUControl = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110: ALUControl = ALU_OR;
            3'b111: ALUControl = ALU_AND;
         endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencer stepping one RV32I instruction through
// fetch/decode/execute/memory/writeback, stalling memory states on mem_ready.
module multicycle_control
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [3:0] ALUControl,
   output logic       RegWrite,
   output logic       illegal,
   output logic [3:0] state_o
);

   state_t     state_q, state_d;
   logic       pc_update, branch, ir_write, mem_write, reg_write;
   logic [1:0] alu_op;

   always_comb begin
      state_d   = state_q;
      pc_update = 1'b0;
      branch    = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      alu_op    = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            ResultSrc = RES_ALURESULT;
            ALUSrcB   = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_update = mem_ready;
            state_d   = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            state_d = decode_next(op);
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc  = 1'b1;
            state_d = mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc    = 1'b1;
            mem_write = 1'b1;
            state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            ALUSrcA = SRCA_RS1;
            alu_op  = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            pc_update = 1'b1;
            state_d   = S_ALUWB;
         end
         S_BEQ: begin
            ALUSrcA = SRCA_RS1;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
            state_d = S_FETCH;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;

   aluDecoder u_alu_dec (
      .ALUOp      (alu_op),
      .funct3     (funct3),
      .funct7_5   (funct7_5),
      .op5        (op[5]),
      .ALUControl (ALUControl)
   );

   // only beq/bne can be taken; other branch funct3 values never redirect the PC
   assign PCWrite  = ~rst & (pc_update | (branch & (funct3[2:1] == 2'b00) & (zero ^ funct3[0])));
   assign IRWrite  = ~rst & ir_write;
   assign MemWrite = ~rst & mem_write;
   assign RegWrite = ~rst & reg_write;
   assign illegal  = ~rst & (state_q == S_TRAP);
   assign state_o  = state_q;
   assign ImmSrc   = (op == OP_STORE)  ? IMM_S :
                     (op == OP_BRANCH) ? IMM_B :
                     (op == OP_JAL)    ? IMM_J : IMM_I;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multicycle RV32I core. It replaces the single-cycle control path with a Moore state machine that steps one instruction through fetch, decode, execute, memory and writeback over 3–5+ cycles. It drives the shared ALU, the unified instruction/data memory port, the instruction-register latch and the PC latch. Memory accesses stall on a ready handshake.

## Interface
- No parameters.
- `clk  in  1`  core clock, all state updates on its rising edge.
- `rst  in  1`  asynchronous, active-high reset.
- `op  in  7`  opcode from the instruction register; stable from DECODE to the end of the instruction.
- `funct3  in  3`  instruction register field.
- `funct7_5  in  1`  instruction register bit 30.
- `zero  in  1`  ALU zero flag, sampled in BEQ.
- `mem_ready  in  1`  memory completes the current access this cycle.
- `PCWrite  out  1`  PC register load enable.
- `AdrSrc  out  1`  memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite  out  1`  memory store strobe.
- `IRWrite  out  1`  loads the instruction register and OldPC.
- `ResultSrc  out  2`  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA  out  2`  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
- `ALUSrcB  out  2`  ALU B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- `ImmSrc  out  2`  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `ALUControl  out  4`  ALU operation.
- `RegWrite  out  1`  register file write enable.
- `illegal  out  1`  core is trapped on an unsupported opcode.
- `state_o  out  4`  current state encoding, for debug and bench use.

## Operation
- States and their encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, TRAP 11.
- Per-state outputs. Anything not listed is 0 / 00. ALUOp is internal: 00 = add, 01 = sub, 10 = funct-decoded.
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00. IRWrite = PCUpdate = mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, which computes the branch target into ALUOut. Next state by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100011 → BEQ
    - anything else → TRAP
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op[5]=0, otherwise MEMWRITE.
  - MEMREAD: AdrSrc=1. Holds until mem_ready, then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=1. MemWrite is held for every stall cycle. Goes to FETCH on mem_ready.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, then ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, then FETCH.
  - TRAP: all strobes are 0 and illegal=1. Exit is by reset only.
- Combinational signals:
  - PCWrite = PCUpdate | (Branch & (zero ^ funct3[0])). funct3=000 is beq, 001 is bne; other branch funct3 values are never taken.
  - ImmSrc is decoded from op in every state: lw / OP-IMM → 00, sw → 01, branch → 10, jal → 11, otherwise 00.
  - ALUControl comes from the ALU decoder using ALUOp, funct3, funct7_5 and op[5]. ALUOp 00 gives ADD (4'b0000); 01 gives SUB (4'b0001).

## Timing
- The state register is the only storage. It resets asynchronously to FETCH.
- All outputs are combinational from state, op, funct3, funct7_5, zero and mem_ready. There is no registered-output latency.
- While rst=1, the following are forced to 0: PCWrite, IRWrite, MemWrite, RegWrite, illegal. Other outputs take their FETCH values: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUControl=0000, state_o=0.
- Cycle counts with mem_ready tied high:
  - R-type, I-type, jal: 4 cycles.
  - lw: 5 cycles.
  - sw, branch: 4 and 3 cycles respectively.
  - Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- mem_ready is ignored in all states other than FETCH, MEMREAD and MEMWRITE.
- Reset asserted mid-instruction: the state becomes FETCH immediately and strobes drop in the same cycle. A partially completed store or load has no further effect.
- zero is used only in the BEQ cycle.

## Structure
- Shared package `riscv_pkg` holds:
  - the `state_t` enum with the encodings above;
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_IMM, OP_JAL, OP_BRANCH);
  - ALUOp and ALUControl constants;
  - ImmSrc, ResultSrc, ALUSrcA and ALUSrcB select constants.
- One sub-module: the existing `aluDecoder`, instantiated unchanged. It maps ALUOp/funct3/funct7_5/op5 to ALUControl.

## Test plan
- **addi x1,x0,5** (op 0010011), mem_ready=1:
  - state_o sequence 0,1,8,7,0.
  - RegWrite=1 only in ALUWB; ALUControl=0000 in EXECI.
- **lw**, mem_ready low for 2 cycles in FETCH and 3 in MEMREAD:
  - state_o 0,0,0,1,2,3,3,3,3,4,0.
  - IRWrite and PCWrite high exactly once; RegWrite with ResultSrc=01 once.
- **sw**, mem_ready low for 2 cycles in MEMWRITE:
  - MemWrite=1 for 3 consecutive cycles with AdrSrc=1, then FETCH.
- **beq** with zero=1 then zero=0; **bne** (funct3=001) with zero=0:
  - PCWrite=1, 0, 1 respectively in the BEQ state.
  - ALUControl=0001 in all three.
- **op=1111111**:
  - DECODE goes to TRAP; illegal=1 and strobes stay 0 for 10 cycles.
  - Asserting rst returns state_o to 0.
- **rst asserted asynchronously mid-MEMWRITE** (between clock edges):
  - MemWrite falls before the next edge; state_o=0.
  - After release, the first FETCH proceeds normally.
